multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
Control FSM that sequences the multicycle RV32I core datapath through fetch, decode, execute, memory and write-back.
- Handshakes with instruction memory and data memory.
- Issues the per-cycle write enables and PC-select to the register file, instruction register and PC.
- Maintains cycle and retired-instruction counters.
- Sits between the decoder/executer datapath and the memories; it is the only block that advances the core state.

Parameters:
CNT_W, 32, width of CYCLE_COUNT and INSTRET
MEM_TIMEOUT, 16, maximum cycles spent in FETCH or MEM waiting for ready before faulting (must be >= 1)

Ports:
CLK  input  1  clock, all logic on rising edge
RST  input  1  synchronous reset, active-high
START  input  1  leave IDLE and begin fetching
OPCODE  input  7  instruction bits [6:0] from the instruction register, valid in DECODE
BRANCH_TAKEN  input  1  branch comparison result from executer, valid in EXECUTE
IMEM_REQ  output  1  instruction memory request
IMEM_READY  input  1  instruction word valid this cycle
DMEM_REQ  output  1  data memory request
DMEM_WE  output  1  data memory write (store)
DMEM_READY  input  1  data memory access complete this cycle
IR_WE  output  1  load instruction register
RF_WE  output  1  register file write
PC_WE  output  1  PC update
PC_SEL  output  2  0 = pc+4, 1 = branch/JAL target, 2 = JALR target
STATE  output  3  current state encoding
HALTED  output  1  in HALT state
ILLEGAL  output  1  sticky: halted on unknown opcode
FAULT  output  1  sticky: halted on memory timeout
CYCLE_COUNT  output  CNT_W  active cycles
INSTRET  output  CNT_W  retired instructions

Behaviour:
- Reset: state IDLE; all enables, requests, HALTED, ILLEGAL, FAULT and both counters 0; wait counter 0.
- Reset applies on any cycle, including mid-FETCH/MEM. Requests drop in the cycle after RST is sampled. In-flight memory responses are ignored.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITE=5, HALT=6.
- STATE, HALTED, IMEM_REQ, DMEM_REQ and DMEM_WE are functions of the registered state/class only.
- IR_WE, RF_WE, PC_WE and PC_SEL are combinational from the registered state, latched class and same-cycle ready/BRANCH_TAKEN.
- IDLE: START=1 moves to FETCH; otherwise stay.
- FETCH: IMEM_REQ=1. IMEM_READY=1 gives IR_WE=1 that cycle and moves to DECODE.
- DECODE: OPCODE is latched into a class register. Classes and opcodes:
  - LOAD 0000011, STORE 0100011, OP 0110011, OP-IMM 0010011
  - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111
  - BRANCH 1100011, SYSTEM 1110011
- DECODE transitions: unknown opcode moves to HALT and sets ILLEGAL; any known opcode moves to EXECUTE. Later OPCODE changes have no effect.
- EXECUTE: one cycle.
  - LOAD/STORE: move to MEM.
  - BRANCH: PC_WE=1, PC_SEL = BRANCH_TAKEN ? 1 : 0; INSTRET+1; move to FETCH.
  - SYSTEM: INSTRET+1; move to HALT with no flag set.
  - Other classes: move to WRITE.
- MEM: DMEM_REQ=1; DMEM_WE=1 only for STORE. On DMEM_READY=1:
  - STORE: PC_WE=1, PC_SEL=0, INSTRET+1, move to FETCH.
  - LOAD: move to WRITE.
- WRITE: RF_WE=1, PC_WE=1; PC_SEL = 1 for JAL, 2 for JALR, else 0; INSTRET+1; move to FETCH.
- RF_WE is never asserted outside WRITE. BRANCH and STORE never assert RF_WE.
- Timeout:
  - Wait counter clears on entry to FETCH/MEM and increments each cycle ready is low.
  - If ready is still low in the MEM_TIMEOUT-th consecutive cycle of a stay: next state HALT, FAULT=1.
  - Ready in that same cycle wins (normal transition).
- HALT: sticky until RST. HALTED=1. START ignored. No enables or requests asserted. Counters frozen.
- CYCLE_COUNT increments every cycle state is neither IDLE nor HALT. Both counters wrap modulo 2^CNT_W without flags.
- Minimum latency with ready always high:
  - OP/OP-IMM/LUI/AUIPC/JAL/JALR: 4 cycles
  - BRANCH: 3 cycles
  - STORE: 4 cycles
  - LOAD: 5 cycles

Test Plan:
1. RST, START=1, OPCODE=0110011, IMEM_READY=1 -> STATE 1,2,3,5,1. RF_WE=PC_WE=1 only in the WRITE cycle, PC_SEL=0. INSTRET=1, CYCLE_COUNT=4.
2. OPCODE=0000011, DMEM_READY high on the 4th MEM cycle -> DMEM_REQ high 4 cycles, DMEM_WE=0. Then WRITE with RF_WE=1. INSTRET=1 after 8 cycles.
3. OPCODE=1100011, BRANCH_TAKEN=1 -> PC_WE=1 and PC_SEL=1 in EXECUTE, RF_WE never high, back in FETCH after 3 cycles. Repeat with BRANCH_TAKEN=0 -> PC_SEL=0.
4. OPCODE=1111111 -> HALT after DECODE with ILLEGAL=1, HALTED=1, STATE=6. START=1 ignored. Counters unchanged for 10 cycles. RST -> IDLE with all flags 0.
5. MEM_TIMEOUT=4, IMEM_READY=0 -> IMEM_REQ high exactly 4 cycles, then HALT with FAULT=1. Rerun with IMEM_READY=1 in the 4th cycle -> DECODE, FAULT=0.
6. RST asserted in the 2nd MEM cycle of a STORE -> DMEM_REQ=0 and STATE=0 next cycle, CYCLE_COUNT=INSTRET=0. Also preload CYCLE_COUNT to all-ones (CNT_W=8) and run one cycle -> wraps to 0.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Sequencing FSM for the multicycle RV32I core. It walks each instruction
//   through fetch, decode, execute, memory and write-back. It handshakes with
//   the instruction and data memories and drives the per-cycle write enables
//   and the PC source select. It also keeps the cycle and retired-instruction
//   counters. No other block advances the core state.
//
// Ports
//   CLK, RST           rising-edge clock, synchronous active-high reset
//   START              leave IDLE and begin fetching
//   OPCODE[6:0]        instruction opcode, sampled in DECODE
//   BRANCH_TAKEN       branch compare result, used in EXECUTE
//   IMEM_REQ/READY     instruction memory handshake
//   DMEM_REQ/WE/READY  data memory handshake (WE = store)
//   IR_WE, RF_WE       instruction register / register file write enables
//   PC_WE, PC_SEL[1:0] PC update; 0 = pc+4, 1 = branch/JAL target, 2 = JALR target
//   STATE[2:0]         current state encoding
//   HALTED             in HALT
//   ILLEGAL, FAULT     sticky halt causes: unknown opcode, memory timeout
//   CYCLE_COUNT        active (non-IDLE, non-HALT) cycles
//   INSTRET            retired instructions
//
// State table
//   state   | meaning
//   IDLE    | waiting for START
//   FETCH   | instruction memory request outstanding
//   DECODE  | opcode classified and latched
//   EXECUTE | single ALU/branch cycle
//   MEM     | data memory request outstanding (LOAD/STORE)
//   WRITE   | register file write-back and PC update
//   HALT    | stopped until reset (SYSTEM, illegal opcode or timeout)

module multicycle_controller #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [6:0]       OPCODE,
    input  logic             BRANCH_TAKEN,
    output logic             IMEM_REQ,
    input  logic             IMEM_READY,
    output logic             DMEM_REQ,
    output logic             DMEM_WE,
    input  logic             DMEM_READY,
    output logic             IR_WE,
    output logic             RF_WE,
    output logic             PC_WE,
    output logic [1:0]       PC_SEL,
    output logic [2:0]       STATE,
    output logic             HALTED,
    output logic             ILLEGAL,
    output logic             FAULT,
    output logic [CNT_W-1:0] CYCLE_COUNT,
    output logic [CNT_W-1:0] INSTRET
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WRITE   = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_LOAD, C_STORE, C_OP, C_OP_IMM, C_LUI,
        C_AUIPC, C_JAL, C_JALR, C_BRANCH, C_SYSTEM
    } class_t;

    // The wait counter only needs to reach MEM_TIMEOUT-1 before the stay ends.
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state, state_next;
    class_t            cls, dec_cls;
    logic              dec_valid;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_ready;
    logic              timeout;
    logic              retire;
    logic              set_illegal;
    logic              set_fault;
    logic              illegal_q, fault_q;
    logic [CNT_W-1:0]  cycle_q, instret_q;

    always_comb begin
        dec_valid = 1'b1;
        dec_cls   = C_OP;
        case (OPCODE)
            7'b0000011: dec_cls = C_LOAD;
            7'b0100011: dec_cls = C_STORE;
            7'b0110011: dec_cls = C_OP;
            7'b0010011: dec_cls = C_OP_IMM;
            7'b0110111: dec_cls = C_LUI;
            7'b0010111: dec_cls = C_AUIPC;
            7'b1101111: dec_cls = C_JAL;
            7'b1100111: dec_cls = C_JALR;
            7'b1100011: dec_cls = C_BRANCH;
            7'b1110011: dec_cls = C_SYSTEM;
            default:    dec_valid = 1'b0;
        endcase
    end

    // Ready of whichever memory the current state waits on. The value only matters in FETCH and MEM.
    assign mem_ready = (state == S_FETCH) ? IMEM_READY : DMEM_READY;
    // Last permitted low-ready cycle of a stay. A ready in this cycle still wins.
    assign timeout   = !mem_ready && (wait_cnt == WAIT_LAST);

    always_comb begin
        state_next  = state;
        IR_WE       = 1'b0;
        RF_WE       = 1'b0;
        PC_WE       = 1'b0;
        PC_SEL      = 2'd0;
        retire      = 1'b0;
        set_illegal = 1'b0;
        set_fault   = 1'b0;
        case (state)
            S_IDLE: begin
                if (START) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (IMEM_READY) begin
                    IR_WE      = 1'b1;
                    state_next = S_DECODE;
                end else if (timeout) begin
                    set_fault  = 1'b1;
                    state_next = S_HALT;
                end
            end
            S_DECODE: begin
                if (dec_valid) begin
                    state_next = S_EXECUTE;
                end else begin
                    set_illegal = 1'b1;
                    state_next  = S_HALT;
                end
            end
            S_EXECUTE: begin
                case (cls)
                    C_LOAD, C_STORE: state_next = S_MEM;
                    C_BRANCH: begin
                        PC_WE      = 1'b1;
                        PC_SEL     = BRANCH_TAKEN ? 2'd1 : 2'd0;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                    C_SYSTEM: begin
                        retire     = 1'b1;
                        state_next = S_HALT;
                    end
                    default: state_next = S_WRITE;
                endcase
            end
            S_MEM: begin
                if (DMEM_READY) begin
                    if (cls == C_STORE) begin
                        PC_WE      = 1'b1;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WRITE;
                    end
                end else if (timeout) begin
                    set_fault  = 1'b1;
                    state_next = S_HALT;
                end
            end
            S_WRITE: begin
                RF_WE      = 1'b1;
                PC_WE      = 1'b1;
                PC_SEL     = (cls == C_JAL) ? 2'd1 : ((cls == C_JALR) ? 2'd2 : 2'd0);
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            cls       <= C_OP;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            state <= state_next;
            if (state == S_DECODE) cls <= dec_cls;
            // Any state change starts a fresh stay, so entry to FETCH/MEM sees a zero count.
            if (state_next != state)
                wait_cnt <= '0;
            else if ((state == S_FETCH || state == S_MEM) && !mem_ready)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (set_illegal) illegal_q <= 1'b1;
            if (set_fault)   fault_q   <= 1'b1;
            if (state != S_IDLE && state != S_HALT) cycle_q <= cycle_q + CNT_W'(1);
            if (retire) instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign STATE       = state;
    assign HALTED      = (state == S_HALT);
    assign IMEM_REQ    = (state == S_FETCH);
    assign DMEM_REQ    = (state == S_MEM);
    assign DMEM_WE     = (state == S_MEM) && (cls == C_STORE);
    assign ILLEGAL     = illegal_q;
    assign FAULT       = fault_q;
    assign CYCLE_COUNT = cycle_q;
    assign INSTRET     = instret_q;

endmodule
